axi4lite_pwm_ctrl_slave: RTL and testbench

- AXI4-Lite responder (slave) holding the control/status register bank for the I2S-to-PWM core.
- Accepts writes and reads from the PS or a VIP master; drives PWM configuration outputs to the core and returns core status.
- Independent AW/W acceptance, one outstanding write and one outstanding read, full VALID/READY backpressure on B and R.

---
 rtl/axi4lite_pwm_ctrl_slave.sv | 109 ++++++++++
 tb/tb_axi4lite_pwm_ctrl_slave.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_pwm_ctrl_slave.sv
// axi4lite_pwm_ctrl_slave: AXI4-Lite register bank (CTRL/PERIOD/DUTY/STATUS) for the I2S-to-PWM core; ports: AXI4-Lite slave on s00_axi_*, pwm_enable/pwm_clear/pwm_period/pwm_duty to the core, status_in/event_in from the core
module axi4lite_pwm_ctrl_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] PERIOD_RST = 32'h0000_0100
) (
  input  logic                          s00_axi_aclk,
  input  logic                          s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
  input  logic [2:0]                    s00_axi_awprot,
  input  logic                          s00_axi_awvalid,
  output logic                          s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] s00_axi_wdata,
  input  logic [3:0]                    s00_axi_wstrb,
  input  logic                          s00_axi_wvalid,
  output logic                          s00_axi_wready,
  output logic [1:0]                    s00_axi_bresp,
  output logic                          s00_axi_bvalid,
  input  logic                          s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
  input  logic [2:0]                    s00_axi_arprot,
  input  logic                          s00_axi_arvalid,
  output logic                          s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s00_axi_rdata,
  output logic [1:0]                    s00_axi_rresp,
  output logic                          s00_axi_rvalid,
  input  logic                          s00_axi_rready,
  output logic                          pwm_enable,
  output logic                          pwm_clear,
  output logic [31:0]                   pwm_period,
  output logic [31:0]                   pwm_duty,
  input  logic [30:0]                   status_in,
  input  logic                          event_in
);
  logic aw_held, w_held, sticky, aw_hs, w_hs, ar_hs, commit, unused_ok;
  logic [1:0] aw_idx, widx;
  logic [3:0] w_strb, ws;
  logic [31:0] w_data, wd, ctrl, period, duty, rd_mux;
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = s[i] ? d[8*i+:8] : o[8*i+:8];
    return r;
  endfunction
  assign s00_axi_awready = !s00_axi_areset && !aw_held && !s00_axi_bvalid;
  assign s00_axi_wready = !s00_axi_areset && !w_held && !s00_axi_bvalid;
  assign s00_axi_arready = !s00_axi_areset && !s00_axi_rvalid;
  assign s00_axi_bresp = 2'b00;
  assign s00_axi_rresp = 2'b00;
  assign pwm_enable = ctrl[0];
  assign pwm_period = period;
  assign pwm_duty = duty;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
  always_comb begin
    aw_hs = s00_axi_awvalid && s00_axi_awready;
    w_hs = s00_axi_wvalid && s00_axi_wready;
    ar_hs = s00_axi_arvalid && s00_axi_arready;
    // a channel counts as available when latched earlier or handshaking right now
    commit = (aw_held || aw_hs) && (w_held || w_hs);
    widx = aw_held ? aw_idx : s00_axi_awaddr[3:2];
    wd = w_held ? w_data : s00_axi_wdata;
    ws = w_held ? w_strb : s00_axi_wstrb;
    rd_mux = s00_axi_araddr[3:2] == 2'd0 ? ctrl :
             s00_axi_araddr[3:2] == 2'd1 ? period :
             s00_axi_araddr[3:2] == 2'd2 ? duty : {sticky, status_in};
  end
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      s00_axi_bvalid <= 1'b0;
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata <= '0;
      ctrl <= '0;
      period <= PERIOD_RST;
      duty <= '0;
      sticky <= 1'b0;
      pwm_clear <= 1'b0;
    end else begin
      if (aw_hs && !commit) begin
        aw_held <= 1'b1;
        aw_idx <= s00_axi_awaddr[3:2];
      end
      if (w_hs && !commit) begin
        w_held <= 1'b1;
        w_data <= s00_axi_wdata;
        w_strb <= s00_axi_wstrb;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
        s00_axi_bvalid <= 1'b1;
      end else if (s00_axi_bvalid && s00_axi_bready) s00_axi_bvalid <= 1'b0;
      // CTRL[1] is a strobe, never stored
      if (commit && widx == 2'd0) ctrl <= merge(ctrl, wd, ws) & ~32'h2;
      if (commit && widx == 2'd1) period <= merge(period, wd, ws);
      if (commit && widx == 2'd2) duty <= merge(duty, wd, ws);
      pwm_clear <= commit && widx == 2'd0 && ws[0] && wd[1];
      // a coincident event wins over the write-1-to-clear
      sticky <= event_in || (sticky && !(commit && widx == 2'd3 && ws[3] && wd[31]));
      if (ar_hs) begin
        s00_axi_rdata <= rd_mux;
        s00_axi_rvalid <= 1'b1;
      end else if (s00_axi_rvalid && s00_axi_rready) s00_axi_rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi4lite_pwm_ctrl_slave.sv
// tb_axi4lite_pwm_ctrl_slave: table-driven and directed checks of the PWM control register slave
module tb_axi4lite_pwm_ctrl_slave;
  logic clk = 0, areset = 1;
  logic [3:0] awaddr = 0, araddr = 0, wstrb = 0;
  logic [2:0] awprot = 0, arprot = 0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0, event_in = 0;
  logic awready, wready, bvalid, arready, rvalid, pwm_enable, pwm_clear;
  logic [31:0] wdata = 0, rdata, pwm_period, pwm_duty;
  logic [1:0] bresp, rresp;
  logic [30:0] status_in = 0;
  int checks = 0, errors = 0, clr_cnt = 0;
  typedef struct {
    logic wr;
    logic [3:0] addr;
    logic [31:0] data;
    logic [3:0] strb;
    logic [30:0] st;
    logic [31:0] exp;
    logic en;
  } vec_t;
  vec_t tbl[18];
  axi4lite_pwm_ctrl_slave dut (
    .s00_axi_aclk(clk), .s00_axi_areset(areset),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .pwm_enable(pwm_enable), .pwm_clear(pwm_clear), .pwm_period(pwm_period), .pwm_duty(pwm_duty),
    .status_in(status_in), .event_in(event_in)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (pwm_clear) clr_cnt++;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_ok, w_ok;
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    aw_ok = 0; w_ok = 0; n = 0;
    while (!(aw_ok && w_ok) && n < 20) begin
      if (awvalid && awready) aw_ok = 1;
      if (wvalid && wready) w_ok = 1;
      tick;
      if (aw_ok) awvalid = 0;
      if (w_ok) wvalid = 0;
      n++;
    end
    awvalid = 0; wvalid = 0; n = 0;
    while (!bvalid && n < 20) begin tick; n++; end
    chk("wr_bvalid", bvalid, 1);
    chk("bresp", bresp, 0);
    tick;
  endtask
  task automatic rd(input logic [3:0] a, output logic [31:0] q);
    int n;
    araddr = a; arvalid = 1; rready = 1; n = 0;
    while (!arready && n < 20) begin tick; n++; end
    tick;
    arvalid = 0;
    chk("rd_rvalid", rvalid, 1);
    chk("rresp", rresp, 0);
    q = rdata;
    tick;
  endtask
  initial begin
    logic [31:0] q, held;
    int c0, bcnt;
    tbl[0]  = '{1'b1, 4'h0, 32'h1, 4'hf, 31'h0, 32'h0, 1'b1};
    tbl[1]  = '{1'b1, 4'h4, 32'h2, 4'hf, 31'h0, 32'h0, 1'b1};
    tbl[2]  = '{1'b1, 4'h8, 32'h3, 4'hf, 31'h0, 32'h0, 1'b1};
    tbl[3]  = '{1'b1, 4'hc, 32'h4, 4'hf, 31'h0, 32'h0, 1'b1};
    tbl[4]  = '{1'b0, 4'h0, 32'h0, 4'h0, 31'h0, 32'h1, 1'b1};
    tbl[5]  = '{1'b0, 4'h4, 32'h0, 4'h0, 31'h0, 32'h2, 1'b1};
    tbl[6]  = '{1'b0, 4'h8, 32'h0, 4'h0, 31'h0, 32'h3, 1'b1};
    tbl[7]  = '{1'b0, 4'hc, 32'h0, 4'h0, 31'h0, 32'h0, 1'b1};
    tbl[8]  = '{1'b1, 4'h4, 32'hffff_ffff, 4'h0, 31'h0, 32'h0, 1'b1};
    tbl[9]  = '{1'b0, 4'h5, 32'h0, 4'h0, 31'h0, 32'h2, 1'b1};
    tbl[10] = '{1'b1, 4'h8, 32'haabb_ccdd, 4'hf, 31'h0, 32'h0, 1'b1};
    tbl[11] = '{1'b1, 4'h8, 32'h1122_3344, 4'h5, 31'h0, 32'h0, 1'b1};
    tbl[12] = '{1'b0, 4'ha, 32'h0, 4'h0, 31'h0, 32'haa22_cc44, 1'b1};
    tbl[13] = '{1'b0, 4'hc, 32'h0, 4'h0, 31'h5555_1234, 32'h5555_1234, 1'b1};
    tbl[14] = '{1'b1, 4'hc, 32'h7fff_ffff, 4'hf, 31'h5555_1234, 32'h0, 1'b1};
    tbl[15] = '{1'b0, 4'hc, 32'h0, 4'h0, 31'h5555_1234, 32'h5555_1234, 1'b1};
    tbl[16] = '{1'b1, 4'h0, 32'hffff_fffc, 4'hf, 31'h0, 32'h0, 1'b0};
    tbl[17] = '{1'b0, 4'h0, 32'h0, 4'h0, 31'h0, 32'hffff_fffc, 1'b0};
    tick; tick; tick;
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_period", pwm_period, 32'h100);
    chk("rst_duty", pwm_duty, 0);
    chk("rst_enable", pwm_enable, 0);
    areset = 0;
    tick;
    c0 = clr_cnt;
    for (int i = 0; i < 18; i++) begin
      status_in = tbl[i].st;
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data, tbl[i].strb);
      else begin
        rd(tbl[i].addr, q);
        chk($sformatf("tbl%0d_rdata", i), q, tbl[i].exp);
      end
      chk($sformatf("tbl%0d_enable", i), pwm_enable, tbl[i].en);
    end
    chk("tbl_no_clear", clr_cnt - c0, 0);
    chk("tbl_period", pwm_period, 32'h2);
    chk("tbl_duty", pwm_duty, 32'haa22_cc44);
    // pwm_clear pulse
    wr(4'h0, 32'h0, 4'hf);
    c0 = clr_cnt;
    awaddr = 4'h0; wdata = 32'h2; wstrb = 4'hf; awvalid = 1; wvalid = 1; bready = 1;
    chk("clr_before", pwm_clear, 0);
    tick;
    awvalid = 0; wvalid = 0;
    chk("clr_bvalid", bvalid, 1);
    chk("clr_pulse", pwm_clear, 1);
    tick;
    chk("clr_after", pwm_clear, 0);
    tick; tick;
    chk("clr_count", clr_cnt - c0, 1);
    chk("clr_enable", pwm_enable, 0);
    rd(4'h0, q);
    chk("clr_readback", q, 0);
    // AW leads W by 5 cycles, then W leads AW
    for (int o = 0; o < 2; o++) begin
      bcnt = 0; bready = 1;
      awaddr = 4'h4; wdata = 32'h1000 + o; wstrb = 4'hf;
      if (o == 0) awvalid = 1; else wvalid = 1;
      tick;
      awvalid = 0; wvalid = 0;
      chk("skew_held_ready", o == 0 ? awready : wready, 0);
      chk("skew_other_ready", o == 0 ? wready : awready, 1);
      for (int k = 0; k < 5; k++) begin
        bcnt += int'(bvalid);
        tick;
      end
      if (o == 0) wvalid = 1; else awvalid = 1;
      tick;
      awvalid = 0; wvalid = 0;
      chk("skew_bvalid_lat", bvalid, 1);
      for (int k = 0; k < 4; k++) begin
        bcnt += int'(bvalid);
        tick;
      end
      chk("skew_bvalid_count", bcnt, 1);
      chk("skew_period", pwm_period, 32'h1000 + o);
    end
    // B backpressure
    bready = 0;
    awaddr = 4'h8; wdata = 32'hdead_beef; wstrb = 4'hf; awvalid = 1; wvalid = 1;
    tick;
    awvalid = 0; wvalid = 0;
    for (int k = 0; k < 10; k++) begin
      chk("bp_awready", awready, 0);
      chk("bp_wready", wready, 0);
      chk("bp_bvalid", bvalid, 1);
      tick;
    end
    bready = 1;
    tick;
    chk("bp_release", bvalid, 0);
    wr(4'h4, 32'h55, 4'hf);
    chk("bp_next_period", pwm_period, 32'h55);
    // R backpressure with a concurrent write to the same register
    araddr = 4'h8; arvalid = 1; rready = 0;
    tick;
    arvalid = 0;
    held = rdata;
    chk("rbp_first", held, 32'hdead_beef);
    wr(4'h8, 32'h0bad_f00d, 4'hf);
    for (int k = 0; k < 10; k++) begin
      chk("rbp_rvalid", rvalid, 1);
      chk("rbp_arready", arready, 0);
      chk("rbp_rdata", rdata, held);
      tick;
    end
    rready = 1;
    tick;
    chk("rbp_release", rvalid, 0);
    rd(4'h8, q);
    chk("rbp_next", q, 32'h0bad_f00d);
    // sticky event bit
    status_in = 31'h0000_00a5;
    event_in = 1;
    tick;
    event_in = 0;
    rd(4'hc, q);
    chk("sticky_set", q, 32'h8000_00a5);
    event_in = 1;
    wr(4'hc, 32'h8000_0000, 4'hf);
    event_in = 0;
    rd(4'hc, q);
    chk("sticky_set_wins", q, 32'h8000_00a5);
    wr(4'hc, 32'h8000_0000, 4'h7);
    rd(4'hc, q);
    chk("sticky_no_strb3", q, 32'h8000_00a5);
    wr(4'hc, 32'h8000_0000, 4'hf);
    rd(4'hc, q);
    chk("sticky_cleared", q, 32'h0000_00a5);
    // reset while AW is held and W pending
    wr(4'h0, 32'h1, 4'hf);
    chk("pre_rst_enable", pwm_enable, 1);
    bready = 1;
    awaddr = 4'h4; awvalid = 1;
    tick;
    awvalid = 0;
    areset = 1; wvalid = 1; wdata = 32'h9999; wstrb = 4'hf;
    tick;
    chk("mid_rst_wready", wready, 0);
    areset = 0; wvalid = 0;
    bcnt = 0;
    for (int k = 0; k < 5; k++) begin
      bcnt += int'(bvalid);
      tick;
    end
    chk("mid_rst_no_b", bcnt, 0);
    chk("mid_rst_period", pwm_period, 32'h100);
    chk("mid_rst_duty", pwm_duty, 0);
    chk("mid_rst_enable", pwm_enable, 0);
    chk("mid_rst_awready", awready, 1);
    wr(4'h4, 32'h77, 4'hf);
    rd(4'h4, q);
    chk("post_rst_write", q, 32'h77);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
